// File: rtl/tm_host_sequencer.sv
// Host-side sequencer for the convolutional Tsetlin-machine core: loads clause and
// weight arrays, runs one image per infer command and returns the class over valid/ready.
module tm_host_sequencer #(
    parameter int CLAUSEN      = 10,
    parameter int CLASSN       = 10,
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 32,
    parameter int CLAUSE_WIDTH = (35 + HEIGHT + WIDTH) * 2,
    parameter int TIMEOUT      = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [8:0]                  cfg_clauses,
    input  logic [$clog2(CLASSN)-1:0]   cfg_classes,
    input  logic                        cmd_load,
    input  logic                        cmd_infer,
    input  logic                        ld_valid,
    input  logic [CLAUSE_WIDTH-1:0]     ld_data,
    output logic                        ld_ready,
    input  logic                        img_valid,
    input  logic                        done,
    input  logic [$clog2(CLASSN)-1:0]   class_op,
    output logic                        wea,
    output logic [$clog2(CLAUSEN)-1:0]  bram_addr_a,
    output logic [CLAUSE_WIDTH-1:0]     clause_write,
    output logic                        wea2,
    output logic [$clog2(CLASSN)-1:0]   bram_addr_a2,
    output logic [9*CLAUSEN-1:0]        weight_write,
    output logic                        img_rst,
    output logic                        done_rmu,
    output logic                        res_valid,
    output logic [$clog2(CLASSN)-1:0]   res_class,
    input  logic                        res_ready,
    output logic                        busy,
    output logic                        model_loaded,
    output logic [1:0]                  err
);

    localparam int AW = $clog2(CLAUSEN);
    localparam int KW = $clog2(CLASSN);
    localparam int WW = 9 * CLAUSEN;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_CLAUSE = 3'd1,
        LD_WEIGHT = 3'd2,
        IMG_RST   = 3'd3,
        WAIT_IMG  = 3'd4,
        START     = 3'd5,
        RUN       = 3'd6,
        RESULT    = 3'd7
    } state_t;

    state_t      state_r;
    logic [1:0]  rst_sync_r;
    logic        rst_int_n_s;
    logic [8:0]  idx_r;
    logic [8:0]  nc_r;
    logic [8:0]  nk_r;
    logic [15:0] tm_cnt_r;
    logic [8:0]  nc_clamp_s;
    logic [8:0]  nk_clamp_s;

    // Reset asserts asynchronously but is released on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // Clamp requested counts: zero or oversize means the full array
    always_comb begin
        nc_clamp_s = 9'(CLAUSEN);
        nk_clamp_s = 9'(CLASSN);
        if ((cfg_clauses == 9'd0) || (cfg_clauses > 9'(CLAUSEN))) begin
            nc_clamp_s = 9'(CLAUSEN);
        end else begin
            nc_clamp_s = cfg_clauses;
        end
        if ((cfg_classes == KW'(0)) || (9'(cfg_classes) > 9'(CLASSN))) begin
            nk_clamp_s = 9'(CLASSN);
        end else begin
            nk_clamp_s = 9'(cfg_classes);
        end
    end

    // Sequencer FSM; every output is a register driven from here
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r      <= IDLE;
            idx_r        <= 9'd0;
            nc_r         <= 9'd0;
            nk_r         <= 9'd0;
            tm_cnt_r     <= 16'd0;
            ld_ready     <= 1'b0;
            wea          <= 1'b0;
            bram_addr_a  <= AW'(0);
            clause_write <= CLAUSE_WIDTH'(0);
            wea2         <= 1'b0;
            bram_addr_a2 <= KW'(0);
            weight_write <= WW'(0);
            img_rst      <= 1'b0;
            done_rmu     <= 1'b0;
            res_valid    <= 1'b0;
            res_class    <= KW'(0);
            busy         <= 1'b0;
            model_loaded <= 1'b0;
            err          <= 2'b00;
        end else begin
            wea      <= 1'b0;
            wea2     <= 1'b0;
            img_rst  <= 1'b0;
            done_rmu <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_load) begin
                        state_r      <= LD_CLAUSE;
                        busy         <= 1'b1;
                        ld_ready     <= 1'b1;
                        model_loaded <= 1'b0;
                        err          <= 2'b00;
                        idx_r        <= 9'd0;
                        nc_r         <= nc_clamp_s;
                        nk_r         <= nk_clamp_s;
                    end else if (cmd_infer && model_loaded) begin
                        state_r <= IMG_RST;
                        busy    <= 1'b1;
                        img_rst <= 1'b1;
                        err     <= 2'b00;
                    end else if (cmd_infer) begin
                        err[1] <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LD_CLAUSE: begin
                    if (ld_valid && ld_ready) begin
                        wea          <= 1'b1;
                        bram_addr_a  <= idx_r[AW-1:0];
                        clause_write <= ld_data;
                        if (idx_r == nc_r - 9'd1) begin
                            idx_r   <= 9'd0;
                            state_r <= LD_WEIGHT;
                        end else begin
                            idx_r <= idx_r + 9'd1;
                        end
                    end
                end
                LD_WEIGHT: begin
                    if (ld_valid && ld_ready) begin
                        wea2         <= 1'b1;
                        bram_addr_a2 <= idx_r[KW-1:0];
                        weight_write <= ld_data[WW-1:0];
                        if (idx_r == nk_r - 9'd1) begin
                            idx_r        <= 9'd0;
                            state_r      <= IDLE;
                            busy         <= 1'b0;
                            ld_ready     <= 1'b0;
                            model_loaded <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 9'd1;
                        end
                    end
                end
                IMG_RST: begin
                    state_r <= WAIT_IMG;
                end
                WAIT_IMG: begin
                    if (img_valid) begin
                        state_r  <= START;
                        done_rmu <= 1'b1;
                    end
                end
                // done is not looked at here: the core was just reset by img_rst
                START: begin
                    tm_cnt_r <= 16'd0;
                    state_r  <= RUN;
                end
                RUN: begin
                    if (done) begin
                        res_class <= class_op;
                        res_valid <= 1'b1;
                        state_r   <= RESULT;
                    end else if (tm_cnt_r == 16'(TIMEOUT - 1)) begin
                        err[0]  <= 1'b1;
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        tm_cnt_r <= tm_cnt_r + 16'd1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
